tqv_periph_arbiter: RTL and testbench
=====================================

Name: tqv_periph_arbiter

Overview:
Two-port round-robin arbiter that shares one TinyQV peripheral register bus (address / data_in / data_write_n / data_read_n / data_out / data_ready) between two requesters, e.g. the SPI register bridge and an on-chip test sequencer.
- Latches the granted request and drives the bus from registers.
- Writes: exactly one strobe cycle. Reads: read strobe held until data_ready.
- Returns width-masked read data with a one-cycle done pulse.

Parameters:
ADDR_W, 6, peripheral address width
DATA_W, 32, data width (fixed at 32; txn masking assumes 32)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
m0_req  in  1  port 0 request; held high until m0_done
m0_we  in  1  1=write, 0=read
m0_txn  in  2  00 byte, 01 half, 10 word, 11 no-op
m0_addr  in  ADDR_W  register address
m0_wdata  in  DATA_W  write data
m0_rdata  out  DATA_W  read data, valid when m0_done=1
m0_done  out  1  one-cycle completion pulse
m1_req, m1_we, m1_txn, m1_addr, m1_wdata, m1_rdata, m1_done  same as port 0, for port 1
address  out  ADDR_W  to peripheral
data_in  out  DATA_W  write data to peripheral
data_write_n  out  2  write strobe (11 = idle)
data_read_n  out  2  read strobe (11 = idle)
data_out  in  DATA_W  read data from peripheral
data_ready  in  1  peripheral read-data valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock is clk; reset is asynchronous, active-low, named rst_n.
- All outputs are registered.
- Reset values:
  - address = 0, data_in = 0
  - data_write_n = 11, data_read_n = 11
  - mN_done = 0, mN_rdata = 0, busy = 0
  - last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - Any req high: grant one port. Only one requesting: that port. Both requesting: the port != last_grant.
  - On grant, latch we/txn/addr/wdata, set last_grant to the granted port, and go to:
    - WRITE if we=1 and txn!=11
    - READ if we=0 and txn!=11
    - DONE if txn=11
- WRITE:
  - Occupies exactly one cycle, starting the cycle after the grant edge: data_write_n = txn, address and data_in = latched values.
  - Next state DONE. Write strobe returns to 11.
- READ:
  - data_read_n = txn and address are driven from the cycle after the grant edge.
  - On each edge with data_ready=1, capture data_out masked:
    - txn 00 keeps [7:0]
    - txn 01 keeps [15:0]
    - txn 10 keeps all 32 bits
  - Capture goes to the granted port's rdata; data_read_n returns to 11; next state DONE.
  - data_ready is ignored while in IDLE, WRITE or DONE.
- DONE:
  - Granted port's mN_done = 1 for exactly this cycle. Next state IDLE.
  - For no-op, rdata = 0.
  - The requester must drop req on the edge where it samples done. A req still high in the following IDLE is a new request.
- Latency:
  - Write: grant edge to done = 2 cycles.
  - Read: grant edge to done = data_ready wait + 2 cycles.
  - Minimum back-to-back spacing: 3 cycles per write.
- Isolation:
  - The non-granted port's rdata/done are unchanged.
  - Changes to any req/addr/wdata after the grant edge have no effect on the current transaction.
- Reset asserted mid-transaction: bus goes idle immediately (asynchronous), FSM goes to IDLE, any pending done is lost, last_grant = 1.

Optional Feature:
Macro TQV_ARB_READ_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to READ and increments each cycle in READ.
  - If it reaches 255 without data_ready, the arbiter returns rdata = 32'hFFFFFFFF (unmasked), drops data_read_n, and goes to DONE.
  - A sticky output timeout_err (1 bit, reset 0) is set. It clears only on reset.
- Not defined: READ waits indefinitely; the timeout_err port is absent.

Test Plan:
- Port 0 word write, addr 6'h04, wdata 32'h12345678 -> exactly one cycle with data_write_n=10, address=04, data_in=12345678; m0_done pulses 2 cycles after grant.
- Port 1 byte read, addr 6'h08; peripheral returns data_out=32'hAABBCCDD with data_ready after 3 cycles -> m1_rdata=32'h000000DD, m1_done pulses once, data_read_n=00 for the whole wait.
- Both ports request continuously from reset -> grants alternate 0,1,0,1; neither port starves; no overlapping strobes.
- Port 0 requests with txn=11 -> no strobe on data_write_n/data_read_n; m0_done pulses with m0_rdata=0.
- rst_n low while READ is waiting on data_ready -> data_read_n=11 and busy=0 immediately; no done pulse; after release, port 0 wins the first tie.
- With TQV_ARB_READ_TIMEOUT_EN defined, a read that never gets data_ready -> done pulses after 255 READ cycles, rdata=FFFFFFFF, timeout_err=1.

Source files
------------

// File: rtl/tqv_periph_arbiter.sv
// Two-port round-robin arbiter sharing one TinyQV peripheral register bus.
// Optional read timeout enabled by defining TQV_ARB_READ_TIMEOUT_EN, which adds
// the sticky timeout_err output.
module tqv_periph_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_txn,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_txn,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic [1:0]        data_write_n,
    output logic [1:0]        data_read_n,
    input  logic [DATA_W-1:0] data_out,
    input  logic              data_ready,
    output logic              busy
`ifdef TQV_ARB_READ_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam logic [1:0] TXN_BYTE = 2'b00;
    localparam logic [1:0] TXN_HALF = 2'b01;
    localparam logic [1:0] TXN_NOP  = 2'b11;
    localparam logic [1:0] STB_IDLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic [1:0]        txn_q, txn_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [1:0]        write_n_q, write_n_d;
    logic [1:0]        read_n_q, read_n_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              m0_done_q, m0_done_d;
    logic              m1_done_q, m1_done_d;
    logic              busy_q, busy_d;

    // Request selection and completion helpers
    logic              sel;
    logic              sel_we;
    logic [1:0]        sel_txn;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              done_c;
    logic              rd_upd;
    logic [DATA_W-1:0] rd_val;

`ifdef TQV_ARB_READ_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'd254;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
`endif

    // Keep only the bytes the transaction size asks for
    function automatic logic [DATA_W-1:0] mask_rdata(input logic [1:0] txn,
                                                     input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        case (txn)
            TXN_BYTE: r = {{(DATA_W-8){1'b0}}, d[7:0]};
            TXN_HALF: r = {{(DATA_W-16){1'b0}}, d[15:0]};
            default:  r = d;
        endcase
        return r;
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        txn_d        = txn_q;
        address_d    = address_q;
        data_in_d    = data_in_q;
        write_n_d    = write_n_q;
        read_n_d     = read_n_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_done_d    = 1'b0;
        m1_done_d    = 1'b0;
        done_c       = 1'b0;
        rd_upd       = 1'b0;
        rd_val       = '0;
        // Tie goes to the port that was not granted last; otherwise the lone requester
        sel          = (m0_req && m1_req) ? ~last_grant_q : m1_req;
        sel_we       = sel ? m1_we    : m0_we;
        sel_txn      = sel ? m1_txn   : m0_txn;
        sel_addr     = sel ? m1_addr  : m0_addr;
        sel_wdata    = sel ? m1_wdata : m0_wdata;
`ifdef TQV_ARB_READ_TIMEOUT_EN
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d        = sel;
                    last_grant_d = sel;
                    txn_d        = sel_txn;
                    address_d    = sel_addr;
                    data_in_d    = sel_wdata;
                    if (sel_txn == TXN_NOP) begin
                        state_d = ST_DONE;
                        done_c  = 1'b1;
                        rd_upd  = 1'b1;
                    end else if (sel_we) begin
                        state_d   = ST_WRITE;
                        write_n_d = sel_txn;
                    end else begin
                        state_d  = ST_READ;
                        read_n_d = sel_txn;
`ifdef TQV_ARB_READ_TIMEOUT_EN
                        cnt_d    = 8'd0;
`endif
                    end
                end
            end
            ST_WRITE: begin
                write_n_d = STB_IDLE;
                state_d   = ST_DONE;
                done_c    = 1'b1;
            end
            ST_READ: begin
                if (data_ready) begin
                    rd_upd   = 1'b1;
                    rd_val   = mask_rdata(txn_q, data_out);
                    read_n_d = STB_IDLE;
                    state_d  = ST_DONE;
                    done_c   = 1'b1;
`ifdef TQV_ARB_READ_TIMEOUT_EN
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rd_upd    = 1'b1;
                    rd_val    = '1;
                    read_n_d  = STB_IDLE;
                    state_d   = ST_DONE;
                    done_c    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done_c) begin
            if (gnt_d) m1_done_d = 1'b1;
            else       m0_done_d = 1'b1;
        end
        if (rd_upd) begin
            if (gnt_d) m1_rdata_d = rd_val;
            else       m0_rdata_d = rd_val;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state and grant history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            txn_q        <= TXN_NOP;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            txn_q        <= txn_d;
        end
    end

    // Registered bus and requester outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_q  <= '0;
            data_in_q  <= '0;
            write_n_q  <= STB_IDLE;
            read_n_q   <= STB_IDLE;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_done_q  <= 1'b0;
            m1_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            address_q  <= address_d;
            data_in_q  <= data_in_d;
            write_n_q  <= write_n_d;
            read_n_q   <= read_n_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_done_q  <= m0_done_d;
            m1_done_q  <= m1_done_d;
            busy_q     <= busy_d;
        end
    end

`ifdef TQV_ARB_READ_TIMEOUT_EN
    // Read wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`endif

    assign address      = address_q;
    assign data_in      = data_in_q;
    assign data_write_n = write_n_q;
    assign data_read_n  = read_n_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;
    assign m0_done      = m0_done_q;
    assign m1_done      = m1_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_tqv_periph_arbiter.sv
// Bench for tqv_periph_arbiter: vector table driven through a scoreboard plus
// hand sequences for arbitration, reset mid-read and (optionally) read timeout.
module tb_tqv_periph_arbiter;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [1:0]        m0_txn = 2'b11;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_done;
    logic              m1_req = 1'b0, m1_we = 1'b0;
    logic [1:0]        m1_txn = 2'b11;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_done;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [1:0]        data_write_n, data_read_n;
    logic [DATA_W-1:0] data_out = '0;
    logic              data_ready = 1'b0;
    logic              busy;
`ifdef TQV_ARB_READ_TIMEOUT_EN
    logic              timeout_err;
`endif

    always #5 clk = ~clk;

    tqv_periph_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_txn(m0_txn), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_done(m0_done),
        .m1_req(m1_req), .m1_we(m1_we), .m1_txn(m1_txn), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_done(m1_done),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
        .busy(busy)
`ifdef TQV_ARB_READ_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [1:0]  txn;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        int          dly;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] model_rdata [2];
    vec_t        vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_port(input logic p, input logic req, input logic we,
                              input logic [1:0] txn, input logic [5:0] addr,
                              input logic [31:0] wdata);
        if (p) begin
            m1_req = req; m1_we = we; m1_txn = txn; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_txn = txn; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // One transaction on an idle arbiter, with bus-side peripheral model
    task automatic run_vec(input vec_t v);
        sb_t  e;
        sb_t  got;
        int   wr_cyc, rd_cyc, exp_lat;
        logic done_seen, own_done, oth_done;
        @(negedge clk);
        drive_port(v.port, 1'b1, v.we, v.txn, v.addr, v.wdata);
        e.port  = v.port;
        e.rdata = (v.txn == 2'b11) ? 32'h0 : (v.we ? model_rdata[v.port] : v.exp_rdata);
        sb_q.push_back(e);
        model_rdata[v.port] = e.rdata;
        exp_lat   = (v.txn == 2'b11) ? 1 : (v.we ? 2 : v.dly + 2);
        wr_cyc    = 0;
        rd_cyc    = 0;
        done_seen = 1'b0;
        for (int cyc = 1; cyc <= 300 && !done_seen; cyc++) begin
            @(negedge clk);
            own_done = v.port ? m1_done : m0_done;
            oth_done = v.port ? m0_done : m1_done;
            check("other_done_quiet", 32'(oth_done), 32'h0);
            // Changes after grant must not leak into the bus
            drive_port(v.port, 1'b1, v.we, v.txn, ~v.addr, ~v.wdata);
            if (data_write_n != 2'b11) begin
                wr_cyc++;
                check("wr_strobe", 32'(data_write_n), 32'(v.txn));
                check("wr_addr", 32'(address), 32'(v.addr));
                check("wr_data", data_in, v.wdata);
                check("wr_busy", 32'(busy), 32'h1);
                data_ready = 1'b1;
                data_out   = 32'hFFFF_FFFF;
            end else if (data_read_n != 2'b11) begin
                rd_cyc++;
                check("rd_strobe", 32'(data_read_n), 32'(v.txn));
                check("rd_addr", 32'(address), 32'(v.addr));
                check("rd_busy", 32'(busy), 32'h1);
                data_ready = (rd_cyc > v.dly);
                data_out   = (rd_cyc > v.dly) ? v.dout : 32'h5555_5555;
            end else begin
                data_ready = 1'b0;
                data_out   = $urandom;
            end
            if (own_done) begin
                done_seen = 1'b1;
                got = sb_q.pop_front();
                check("sb_port", 32'(got.port), 32'(v.port));
                check("rdata", v.port ? m1_rdata : m0_rdata, got.rdata);
                check("other_rdata", v.port ? m0_rdata : m1_rdata, model_rdata[!v.port]);
                check("latency", 32'(cyc), 32'(exp_lat));
                check("wr_cycles", 32'(wr_cyc), (v.we && v.txn != 2'b11) ? 32'h1 : 32'h0);
                check("rd_cycles", 32'(rd_cyc),
                      (!v.we && v.txn != 2'b11) ? 32'(v.dly + 1) : 32'h0);
                drive_port(v.port, 1'b0, 1'b0, 2'b11, 6'h0, 32'h0);
            end
        end
        if (!done_seen) begin
            check("done_seen", 32'h0, 32'h1);
            drive_port(v.port, 1'b0, 1'b0, 2'b11, 6'h0, 32'h0);
        end
        @(negedge clk);
        check("done_pulse_end", 32'({m1_done, m0_done}), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
    endtask

    // Hold both ports requesting writes and record which port owns each strobe
    task automatic tie_sequence(input int n_expect);
        int k;
        k = 0;
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b1, 2'b10, 6'h11, 32'hA0A0_A0A0);
        drive_port(1'b1, 1'b1, 1'b1, 2'b10, 6'h22, 32'hB1B1_B1B1);
        for (int cyc = 0; cyc < 40 && k < n_expect; cyc++) begin
            @(negedge clk);
            check("no_read_strobe", 32'(data_read_n), 32'h3);
            if (data_write_n != 2'b11) begin
                check("rr_order", 32'(address), (k % 2 == 0) ? 32'h11 : 32'h22);
                k++;
            end
        end
        check("rr_count", 32'(k), 32'(n_expect));
        drive_port(1'b0, 1'b0, 1'b0, 2'b11, 6'h0, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 2'b11, 6'h0, 32'h0);
        repeat (6) @(negedge clk);
        check("rr_idle", 32'(busy), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            port we   txn    addr   wdata         dout          dly exp_rdata
        vecs[0] = '{1'b0, 1'b1, 2'b10, 6'h04, 32'h12345678, 32'h0,        0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 2'b00, 6'h08, 32'h0,        32'hAABBCCDD, 3, 32'h000000DD};
        vecs[2] = '{1'b0, 1'b0, 2'b11, 6'h05, 32'h0,        32'h0,        0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 2'b01, 6'h3F, 32'h0,        32'hCAFEBABE, 0, 32'h0000BABE};
        vecs[4] = '{1'b1, 1'b1, 2'b00, 6'h01, 32'h000000A5, 32'h0,        0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 2'b10, 6'h10, 32'h0,        32'hDEADBEEF, 5, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 1'b1, 2'b01, 6'h22, 32'h0000BEEF, 32'h0,        0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 2'b11, 6'h07, 32'h99999999, 32'h0,        0, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 2'b00, 6'h2A, 32'h0,        32'h12345680, 1, 32'h00000080};
        model_rdata[0] = 32'h0;
        model_rdata[1] = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_address", 32'(address), 32'h0);
        check("rst_data_in", data_in, 32'h0);
        check("rst_write_n", 32'(data_write_n), 32'h3);
        check("rst_read_n", 32'(data_read_n), 32'h3);
        check("rst_done", 32'({m1_done, m0_done}), 32'h0);
        check("rst_rdata0", m0_rdata, 32'h0);
        check("rst_rdata1", m1_rdata, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
`ifdef TQV_ARB_READ_TIMEOUT_EN
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
`endif
        rst_n = 1'b1;

        // data_ready in IDLE must be ignored
        data_ready = 1'b1;
        data_out   = 32'h7777_7777;
        repeat (2) @(negedge clk);
        data_ready = 1'b0;
        check("idle_ready_rdata0", m0_rdata, 32'h0);
        check("idle_ready_rdata1", m1_rdata, 32'h0);
        check("idle_ready_busy", 32'(busy), 32'h0);

        // Continuous requests from reset alternate 0,1,0,1
        tie_sequence(4);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while a read waits on data_ready
        @(negedge clk);
        data_ready = 1'b0;
        drive_port(1'b0, 1'b1, 1'b0, 2'b10, 6'h05, 32'h0);
        repeat (3) @(negedge clk);
        check("pre_rst_read_n", 32'(data_read_n), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        check("async_read_n", 32'(data_read_n), 32'h3);
        check("async_busy", 32'(busy), 32'h0);
        drive_port(1'b0, 1'b0, 1'b0, 2'b11, 6'h0, 32'h0);
        model_rdata[0] = 32'h0;
        model_rdata[1] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_rst", 32'({m1_done, m0_done}), 32'h0);
        end
        tie_sequence(2);

`ifdef TQV_ARB_READ_TIMEOUT_EN
        begin
            int   rd_cyc;
            logic seen;
            rd_cyc = 0;
            seen   = 1'b0;
            @(negedge clk);
            data_ready = 1'b0;
            drive_port(1'b1, 1'b1, 1'b0, 2'b00, 6'h03, 32'h0);
            for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
                @(negedge clk);
                if (data_read_n != 2'b11) rd_cyc++;
                if (m1_done) begin
                    seen = 1'b1;
                    check("to_latency", 32'(cyc), 32'd256);
                    check("to_rd_cycles", 32'(rd_cyc), 32'd255);
                    check("to_rdata", m1_rdata, 32'hFFFF_FFFF);
                    check("to_err", 32'(timeout_err), 32'h1);
                    drive_port(1'b1, 1'b0, 1'b0, 2'b11, 6'h0, 32'h0);
                end
            end
            if (!seen) begin
                check("to_done_seen", 32'h0, 32'h1);
                drive_port(1'b1, 1'b0, 1'b0, 2'b11, 6'h0, 32'h0);
            end
            repeat (3) @(negedge clk);
            check("to_err_sticky", 32'(timeout_err), 32'h1);
        end
`endif

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
